// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer
//   Accepts a pair of WIDTH-bit operands over a valid/ready handshake and
//   replays them LSB-first, one bit pair per beat, to a bit-serial adder.
//   A hold input suppresses the current beat (shown as a vld-low bubble).
//   Back-to-back operands stream with no dead cycle between them.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   in_vld  in   parallel operand pair valid
//   in_rdy  out  operand pair can be accepted this cycle (combinational)
//   in_a    in   operand A [WIDTH-1:0]
//   in_b    in   operand B [WIDTH-1:0]
//   hold    in   suppress the current serial beat
//   vld     out  serial beat valid (combinational on hold/rst)
//   a       out  current bit of A
//   b       out  current bit of B
//   last    out  current beat carries the operand MSB
module serial_operand_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             hold,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last
);

  // Beat counter needs at least one bit so WIDTH=1 stays legal.
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             at_msb;
  logic             accept;

  assign at_msb = (cnt_q == CNT_LAST);

  // Next-state and beat outputs; hold freezes everything while in SHIFT.
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    vld     = 1'b0;
    a       = 1'b0;
    b       = 1'b0;
    last    = 1'b0;
    in_rdy  = 1'b0;
    accept  = 1'b0;

    vld    = (state_q == SHIFT) & ~hold & ~rst;
    a      = sh_a_q[0] & vld;
    b      = sh_b_q[0] & vld;
    last   = vld & at_msb;
    // Ready when empty, or when the MSB beat is leaving this cycle.
    in_rdy = ~rst & ((state_q == IDLE) | last);
    accept = in_vld & in_rdy;

    if (accept) begin
      // Covers both a fresh start from IDLE and the seamless reload on last.
      state_d = SHIFT;
      sh_a_d  = in_a;
      sh_b_d  = in_b;
      cnt_d   = '0;
    end else if (last) begin
      state_d = IDLE;
    end else if (vld) begin
      sh_a_d  = sh_a_q >> 1;
      sh_b_d  = sh_b_q >> 1;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous reset; in-flight operands are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
module tb_serial_operand_serializer;

  logic       clk = 1'b0;
  logic       rst, in_vld, hold;
  logic [7:0] in_a, in_b;

  logic rdy8, vld8, a8, b8, last8;
  logic rdy1, vld1, a1, b1, last1;

  always #5 clk = ~clk;

  serial_operand_serializer #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy8),
    .in_a(in_a), .in_b(in_b), .hold(hold),
    .vld(vld8), .a(a8), .b(b8), .last(last8)
  );

  serial_operand_serializer #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy1),
    .in_a(in_a[0:0]), .in_b(in_b[0:0]), .hold(hold),
    .vld(vld1), .a(a1), .b(b1), .last(last1)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: which operand is in flight and which bit is next.
  int         wid [2] = '{8, 1};
  bit         m_busy [2];
  logic [7:0] m_a [2];
  logic [7:0] m_b [2];
  int         m_idx [2];
  logic [7:0] acc_a [2];
  logic [7:0] acc_b [2];
  logic [7:0] last_sum [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit h, input bit v,
                       input logic [7:0] ia, input logic [7:0] ib);
    logic [4:0]  g [2];
    bit          mv [2];
    bit          ml [2];
    bit          mr [2];
    logic [31:0] mask, s;
    rst = r; hold = h; in_vld = v; in_a = ia; in_b = ib;
    @(negedge clk);
    g[0] = {rdy8, vld8, a8, b8, last8};
    g[1] = {rdy1, vld1, a1, b1, last1};
    for (int d = 0; d < 2; d++) begin
      logic ea, eb;
      mv[d] = m_busy[d] && !h && !r;
      ml[d] = mv[d] && (m_idx[d] == wid[d] - 1);
      mr[d] = !r && (!m_busy[d] || ml[d]);
      ea = mv[d] ? m_a[d][m_idx[d]] : 1'b0;
      eb = mv[d] ? m_b[d][m_idx[d]] : 1'b0;
      check_eq(d == 0 ? "w8_rdy_vld_a_b_last" : "w1_rdy_vld_a_b_last",
               32'(g[d]), 32'({mr[d], mv[d], ea, eb, ml[d]}));
      if (mv[d]) begin
        acc_a[d][m_idx[d]] = g[d][2];
        acc_b[d][m_idx[d]] = g[d][1];
      end
      if (ml[d]) begin
        mask = (32'd1 << wid[d]) - 32'd1;
        s    = (32'(acc_a[d]) + 32'(acc_b[d])) & mask;
        last_sum[d] = 8'(s);
        check_eq(d == 0 ? "w8_serial_sum" : "w1_serial_sum", s,
                 (32'(m_a[d]) + 32'(m_b[d])) & mask);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [7:0] dm;
      dm = (d == 0) ? 8'hFF : 8'h01;
      if (r) begin
        m_busy[d] = 1'b0;
        m_idx[d]  = 0;
      end else if (v && mr[d]) begin
        m_busy[d] = 1'b1;
        m_a[d]    = ia & dm;
        m_b[d]    = ib & dm;
        m_idx[d]  = 0;
        acc_a[d]  = '0;
        acc_b[d]  = '0;
      end else if (ml[d]) begin
        m_busy[d] = 1'b0;
      end else if (mv[d]) begin
        m_idx[d]++;
      end
    end
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_a[d] = '0; m_b[d] = '0; m_idx[d] = 0;
      acc_a[d] = '0; acc_b[d] = '0; last_sum[d] = '0;
    end
    rst = 1'b1; hold = 1'b0; in_vld = 1'b0; in_a = '0; in_b = '0;

    // Reset
    cycle(1, 0, 0, 8'h00, 8'h00);
    cycle(1, 0, 1, 8'h12, 8'h34);
    cycle(0, 0, 0, 8'h00, 8'h00);

    // Single operand 0x5A + 0x3C
    cycle(0, 0, 1, 8'h5A, 8'h3C);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 8'h00, 8'h00);
    check_eq("sum_5a_3c", 32'(last_sum[0]), 32'h96);

    // Back-to-back (FF,01) then (00,00)
    cycle(0, 0, 1, 8'hFF, 8'h01);
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, 8'h00, 8'h00);
    check_eq("sum_ff_01", 32'(last_sum[0]), 32'h00);
    for (int i = 9; i <= 16; i++) cycle(0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 0, 8'h00, 8'h00);

    // Hold bubbles on beats 3-4 and on the last beat
    cycle(0, 0, 1, 8'hC3, 8'h81);
    cycle(0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 0, 8'h00, 8'h00);
    cycle(0, 1, 0, 8'h00, 8'h00);
    cycle(0, 1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 8'h00);
    cycle(0, 1, 1, 8'h99, 8'h99);
    cycle(0, 0, 0, 8'h00, 8'h00);
    check_eq("sum_c3_81", 32'(last_sum[0]), 32'h44);
    cycle(0, 0, 0, 8'h00, 8'h00);

    // Reset mid-operand, then a fresh operand serializes from bit 0
    cycle(0, 0, 1, 8'hAA, 8'h55);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 8'h00);
    cycle(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 1, 8'h01, 8'h01);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 8'h00, 8'h00);
    check_eq("sum_01_01", 32'(last_sum[0]), 32'h02);

    // Busy backpressure with garbage on the parallel inputs
    cycle(0, 0, 1, 8'h3C, 8'h0F);
    for (int i = 1; i <= 7; i++) cycle(0, 0, 1, 8'($urandom), 8'($urandom));
    cycle(0, 0, 1, 8'h77, 8'h11);
    check_eq("sum_3c_0f", 32'(last_sum[0]), 32'h4B);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 8'h00, 8'h00);
    check_eq("sum_77_11", 32'(last_sum[0]), 32'h88);
    cycle(0, 0, 0, 8'h00, 8'h00);

    // WIDTH=1 stream 1,0,1
    cycle(0, 0, 1, 8'h01, 8'h00);
    cycle(0, 0, 1, 8'h00, 8'h01);
    cycle(0, 0, 1, 8'h01, 8'h01);
    cycle(0, 0, 0, 8'h00, 8'h00);
    check_eq("w1_sum_1_1", 32'(last_sum[1]), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 60), 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
